// File: rtl/avalon_burst_agent.sv
// Avalon-MM burst agent backed by an on-chip word memory.
// Serves fixed-length read bursts with programmable first-beat latency and
// inter-beat gaps, and accepts write bursts with zero wait states.
module avalon_burst_agent #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned BURST_W = 6,
  parameter int unsigned LATENCY = 3,
  parameter int unsigned GAP     = 0
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [31:0]        address_i,
  input  logic               read_i,
  input  logic               write_i,
  input  logic [BURST_W-1:0] burstcount_i,
  input  logic [3:0]         byteenable_i,
  input  logic [31:0]        writedata_i,
  output logic [31:0]        readdata_o,
  output logic               readdatavalid_o,
  output logic               waitrequest_o
);

  localparam int unsigned Depth = 2 ** ADDR_W;
  // RD_LAT lasts LATENCY-1 cycles and RD_GAP lasts GAP cycles; both count down to 0.
  localparam logic [3:0] LatLoad = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [3:0] GapLoad = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  typedef enum logic [2:0] {StIdle, StRdLat, StRdData, StRdGap, StWr} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [BURST_W-1:0]  rem_q, rem_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [31:0]         readdata_q;
  logic [31:0]         mem_q [Depth];

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [ADDR_W-1:0]   addr_idx;
  logic [BURST_W-1:0]  req_cnt;
  logic                unused_addr;

  assign addr_idx    = address_i[ADDR_W+1:2];
  assign unused_addr = ^{address_i[31:ADDR_W+2], address_i[1:0]};
  // A burstcount of zero is served as a single beat.
  assign req_cnt     = (burstcount_i == '0) ? BURST_W'(1) : burstcount_i;

  assign readdata_o      = readdata_q;
  assign readdatavalid_o = (state_q == StRdData);
  assign waitrequest_o   = reset_i || (state_q == StRdLat) || (state_q == StRdData) ||
                           (state_q == StRdGap);

  // Next-state, burst bookkeeping and memory write decode.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = idx_q;
    unique case (state_q)
      StIdle: begin
        if (read_i) begin
          idx_d   = addr_idx;
          rem_d   = req_cnt;
          cnt_d   = LatLoad;
          state_d = (LATENCY > 1) ? StRdLat : StRdData;
        end else if (write_i) begin
          mem_we    = 1'b1;
          mem_waddr = addr_idx;
          idx_d     = addr_idx + ADDR_W'(1);
          rem_d     = req_cnt - BURST_W'(1);
          if (req_cnt != BURST_W'(1)) state_d = StWr;
        end
      end
      StWr: begin
        if (write_i) begin
          mem_we = 1'b1;
          idx_d  = idx_q + ADDR_W'(1);
          rem_d  = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) state_d = StIdle;
        end
      end
      StRdLat: begin
        if (cnt_q == 4'd0) state_d = StRdData;
        else cnt_d = cnt_q - 4'd1;
      end
      StRdData: begin
        idx_d = idx_q + ADDR_W'(1);
        rem_d = rem_q - BURST_W'(1);
        if (rem_q == BURST_W'(1)) begin
          state_d = StIdle;
        end else if (GAP > 0) begin
          cnt_d   = GapLoad;
          state_d = StRdGap;
        end
      end
      StRdGap: begin
        if (cnt_q == 4'd0) state_d = StRdData;
        else cnt_d = cnt_q - 4'd1;
      end
      default: state_d = StIdle;
    endcase
    // Reset aborts any burst in flight, including a pending write beat.
    if (reset_i) mem_we = 1'b0;
  end

  // State registers; readdata is loaded on entry to each RD_DATA cycle.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      idx_q      <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      readdata_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      if (state_d == StRdData) readdata_q <= mem_q[idx_d];
    end
  end

  // Word memory with per-byte write enables; no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (byteenable_i[b]) mem_q[mem_waddr][8*b +: 8] <= writedata_i[8*b +: 8];
      end
    end
  end

endmodule
